bram_port_arbiter: RTL

Round-robin burst arbiter sharing one single-port BRAM between the weight fetcher, input fetcher and result writeback of the systolic array. It sits between the tile-level fetch engines (driven by the tile base addresses) and the BRAM. It grants whole bursts, issues consecutive-address beats, and routes read data back to the owning requester. Read-latency tagging keeps returns correct while the next burst is already being issued.

---
 rtl/bram_arb_pkg.sv | 35 +++
 rtl/bram_port_arbiter_rr_arb3.sv | 29 ++
 rtl/bram_port_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter: requester ids, FSM encoding and read tags.
package bram_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_WEIGHT = 2'd0,
    REQ_INPUT  = 2'd1,
    REQ_RESULT = 2'd2
  } req_id_t;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic    valid;
    req_id_t owner;
    logic    last;
  } rd_tag_t;

  // Cyclic add over the requester ids; both operands are always valid ids.
  function automatic req_id_t ptr_add(input req_id_t p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s > {1'b0, REQ_RESULT}) s = s - 3'(NUM_REQ);
    return req_id_t'(s[1:0]);
  endfunction

  function automatic logic [NUM_REQ-1:0] req_onehot(input req_id_t id);
    return 3'b001 << id;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arb3.sv
// Combinational round-robin picker: first requester at or after rr_ptr, cyclic.
module rr_arb3
  import bram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output req_id_t            idx,
  output logic               valid
);

  req_id_t cand;

  always_comb begin
    gnt   = '0;
    idx   = rr_ptr;
    valid = 1'b0;
    cand  = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_add(rr_ptr, 2'(k));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    gnt = req_onehot(idx) & {NUM_REQ{valid}};
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin burst arbiter sharing one single-port BRAM between three requesters.
// ARB   | pick next requester, latch its burst parameters, pulse gnt
// BURST | issue one beat per cycle at consecutive addresses until the count expires
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 2,
  parameter int LEN_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        wr_pop,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  state_t              state_q, state_d;
  req_id_t             rr_ptr_q, rr_ptr_d;
  req_id_t             owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_last_q, mem_last_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [NUM_REQ-1:0]  wdone_q, wdone_d;
  rd_tag_t             tag_q [RD_LAT];
  rd_tag_t             tag_d [RD_LAT];
  rd_tag_t             tag_tap;
  logic                tag_any;

  logic [NUM_REQ-1:0]  pick_gnt;
  req_id_t             pick_idx;
  logic                pick_valid;

  rr_arb3 u_rr_arb3 (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_last_d = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ARB: begin
        // Requester inputs are only looked at here; the burst runs from the latched copy.
        if (pick_valid) begin
          gnt_d    = pick_gnt;
          owner_d  = pick_idx;
          we_d     = req_we[pick_idx];
          addr_d   = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          cnt_d    = req_len[int'(pick_idx)*LEN_W +: LEN_W];
          rr_ptr_d = ptr_add(pick_idx, 2'd1);
          state_d  = BURST;
        end
      end
      BURST: begin
        mem_en_d   = 1'b1;
        mem_we_d   = we_q;
        mem_addr_d = addr_q;
        mem_last_d = (cnt_q == '0);
        addr_d     = addr_q + 1'b1;
        if (cnt_q == '0) begin
          state_d = ARB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // owner_q only changes at the grant edge, which is never earlier than the last beat on the bus.
  always_comb begin
    tag_d[0] = '{valid: mem_en_q & ~mem_we_q, owner: owner_q, last: mem_last_q};
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    tag_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      tag_any = tag_any | tag_q[i].valid;
    end
    wdone_d = req_onehot(owner_q) & {NUM_REQ{mem_en_q & mem_we_q & mem_last_q}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      rr_ptr_q   <= REQ_WEIGHT;
      owner_q    <= REQ_WEIGHT;
      we_q       <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_last_q <= 1'b0;
      mem_addr_q <= '0;
      wdone_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_last_q <= mem_last_d;
      mem_addr_q <= mem_addr_d;
      wdone_q    <= wdone_d;
      tag_q      <= tag_d;
    end
  end

  assign tag_tap   = tag_q[RD_LAT-1];
  assign gnt       = gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = req_wdata[int'(owner_q)*DATA_W +: DATA_W];
  assign wr_pop    = req_onehot(owner_q) & {NUM_REQ{mem_en_q & mem_we_q}};
  assign rvalid    = tag_tap.valid ? req_onehot(tag_tap.owner) : '0;
  assign rdata     = tag_tap.valid ? mem_rdata : '0;
  assign done      = wdone_q | (rvalid & {NUM_REQ{tag_tap.last}});
  assign busy      = (state_q == BURST) | mem_en_q | tag_any | (|gnt_q);

endmodule
